// File: rtl/epu_in_req_buf.sv
// EPU slave-input request buffer: captures AXI-slave handshake strobes into a show-ahead
// command FIFO drained by the EPU core. Optional address range check: EPU_IN_ADDR_CHECK_EN.
module epu_in_req_buf #(
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned OUTST_BITS = 4
`ifdef EPU_IN_ADDR_CHECK_EN
    ,
    parameter logic [ADDR_BITS-1:0] ADDR_LO = '0,
    parameter logic [ADDR_BITS-1:0] ADDR_HI = '1
`endif
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    CS,
    input  logic                    OE,
    input  logic                    arhns,
    input  logic                    awhns,
    input  logic                    whns,
    input  logic                    rdfin,
    input  logic                    wrfin,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [DATA_BITS-1:0]    wdata,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    cmd_we,
    output logic [ADDR_BITS-1:0]    cmd_addr,
    output logic [DATA_BITS-1:0]    cmd_wdata,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic [OUTST_BITS-1:0]   outst,
`ifdef EPU_IN_ADDR_CHECK_EN
    output logic                    addr_err,
`endif
    output logic                    ovf_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [OUTST_BITS-1:0] OUTST_MAX = '1;

    logic                 ar_pend, aw_pend, w_pend;
    logic [ADDR_BITS-1:0] ar_addr, aw_addr;
    logic [DATA_BITS-1:0] w_data;

    logic [PTR_W-1:0]     wptr, rptr;
    logic [PTR_W:0]       cnt;
    logic                 mem_we    [DEPTH];
    logic [ADDR_BITS-1:0] mem_addr  [DEPTH];
    logic [DATA_BITS-1:0] mem_wdata [DEPTH];

    logic ar_stb, aw_stb, w_stb;
    logic pop, can_push, svc_rd, svc_wr, push, pend_err;
    logic push_we;
    logic [ADDR_BITS-1:0] push_addr;
    logic [DATA_BITS-1:0] push_wdata;

    logic [OUTST_BITS-1:0] outst_nxt;
    logic outst_err;
    logic [1:0] fin_cnt, net_dec;

    assign ar_stb = CS & OE & arhns;
    assign aw_stb = CS & awhns;
    assign w_stb  = CS & whns;

    assign cmd_valid = (cnt != '0);
    assign full      = (cnt == FULL_CNT);
    assign count     = cnt;
    assign pop       = cmd_valid & cmd_ready;

    // A slot freed by this cycle's pop may be refilled in the same cycle.
    assign can_push = ~full | pop;
    assign svc_rd   = ar_pend & can_push;
    assign svc_wr   = ~ar_pend & aw_pend & w_pend & can_push;

`ifdef EPU_IN_ADDR_CHECK_EN
    logic rd_ok, wr_ok, discard;
    assign rd_ok   = (ar_addr >= ADDR_LO) && (ar_addr <= ADDR_HI);
    assign wr_ok   = (aw_addr >= ADDR_LO) && (aw_addr <= ADDR_HI);
    assign push    = (svc_rd & rd_ok) | (svc_wr & wr_ok);
    assign discard = (svc_rd & ~rd_ok) | (svc_wr & ~wr_ok);
`else
    assign push = svc_rd | svc_wr;
`endif

    assign push_we    = ~svc_rd;
    assign push_addr  = svc_rd ? ar_addr : aw_addr;
    assign push_wdata = svc_rd ? '0 : w_data;

    assign pend_err = (ar_stb & ar_pend & ~svc_rd) |
                      (aw_stb & aw_pend & ~svc_wr) |
                      (w_stb  & w_pend  & ~svc_wr);

    // Net change is push minus finish pulses; clamp at both ends and flag the clamp.
    always_comb begin
        outst_nxt = outst;
        outst_err = 1'b0;
        fin_cnt   = {1'b0, rdfin} + {1'b0, wrfin};
        net_dec   = '0;
        if (push && (fin_cnt == 2'd0)) begin
            if (outst == OUTST_MAX) outst_err = 1'b1;
            else                    outst_nxt = outst + OUTST_BITS'(1);
        end else if (fin_cnt > {1'b0, push}) begin
            net_dec = fin_cnt - {1'b0, push};
            if (outst < OUTST_BITS'(net_dec)) begin
                outst_nxt = '0;
                outst_err = 1'b1;
            end else begin
                outst_nxt = outst - OUTST_BITS'(net_dec);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ar_pend <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            ar_addr <= '0;
            aw_addr <= '0;
            w_data  <= '0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            outst   <= '0;
            ovf_err <= 1'b0;
`ifdef EPU_IN_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
        end else begin
            if (ar_stb) ar_addr <= addr;
            if (aw_stb) aw_addr <= addr;
            if (w_stb)  w_data  <= wdata;
            ar_pend <= ar_stb | (ar_pend & ~svc_rd);
            aw_pend <= aw_stb | (aw_pend & ~svc_wr);
            w_pend  <= w_stb  | (w_pend  & ~svc_wr);
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            cnt   <= cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            outst <= outst_nxt;
            if (pend_err | outst_err) ovf_err <= 1'b1;
`ifdef EPU_IN_ADDR_CHECK_EN
            if (discard) addr_err <= 1'b1;
`endif
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_we[wptr]    <= push_we;
            mem_addr[wptr]  <= push_addr;
            mem_wdata[wptr] <= push_wdata;
        end
    end

    assign cmd_we    = cmd_valid & mem_we[rptr];
    assign cmd_addr  = cmd_valid ? mem_addr[rptr]  : '0;
    assign cmd_wdata = cmd_valid ? mem_wdata[rptr] : '0;

endmodule

// File: tb/tb_epu_in_req_buf.sv
// Self-checking bench for epu_in_req_buf (default build): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_epu_in_req_buf;

    localparam int DEPTH = 4;
    localparam int OMAX  = 15;

    logic        ACLK, ARESETn, CS, OE, arhns, awhns, whns, rdfin, wrfin;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        cmd_valid, cmd_ready, cmd_we, full, ovf_err;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  count;
    logic [3:0]  outst;

    int n_checks = 0;
    int n_fail   = 0;

    epu_in_req_buf #(.ADDR_BITS(16), .DATA_BITS(32), .DEPTH(4), .OUTST_BITS(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .CS(CS), .OE(OE),
        .arhns(arhns), .awhns(awhns), .whns(whns), .rdfin(rdfin), .wrfin(wrfin),
        .addr(addr), .wdata(wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .full(full), .count(count), .outst(outst), .ovf_err(ovf_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          we;
        logic [15:0] a;
        logic [31:0] d;
    } cmd_t;

    cmd_t        mq[$];
    bit          m_ar, m_aw, m_w, m_err;
    logic [15:0] m_ara, m_awa;
    logic [31:0] m_wd;
    int          m_outst;

    task automatic model_step();
        bit   pop, room, do_rd, do_wr, ar_s, aw_s, w_s;
        int   n;
        cmd_t c;
        if (!ARESETn) begin
            mq.delete();
            m_ar = 0; m_aw = 0; m_w = 0; m_err = 0; m_outst = 0;
            return;
        end
        ar_s  = CS && OE && arhns;
        aw_s  = CS && awhns;
        w_s   = CS && whns;
        pop   = (mq.size() != 0) && cmd_ready;
        room  = (mq.size() < DEPTH) || pop;
        do_rd = m_ar && room;
        do_wr = !m_ar && m_aw && m_w && room;
        if (pop) void'(mq.pop_front());
        if (do_rd) begin
            c.we = 0; c.a = m_ara; c.d = '0; mq.push_back(c);
        end else if (do_wr) begin
            c.we = 1; c.a = m_awa; c.d = m_wd; mq.push_back(c);
        end
        if ((ar_s && m_ar && !do_rd) || (aw_s && m_aw && !do_wr) || (w_s && m_w && !do_wr))
            m_err = 1;
        m_ar = ar_s || (m_ar && !do_rd);
        m_aw = aw_s || (m_aw && !do_wr);
        m_w  = w_s  || (m_w  && !do_wr);
        if (ar_s) m_ara = addr;
        if (aw_s) m_awa = addr;
        if (w_s)  m_wd  = wdata;
        n = m_outst + ((do_rd || do_wr) ? 1 : 0) - int'(rdfin) - int'(wrfin);
        if (n > OMAX) begin n = OMAX; m_err = 1; end
        if (n < 0)    begin n = 0;    m_err = 1; end
        m_outst = n;
    endtask

    // One clock: model consumes the inputs seen at this edge, then pulses are dropped.
    task automatic step();
        model_step();
        @(posedge ACLK);
        #1;
        arhns = 0; awhns = 0; whns = 0; rdfin = 0; wrfin = 0;
    endtask

    task automatic do_reset();
        ARESETn = 0;
        step();
        ARESETn = 1;
    endtask

    task automatic test_reset();
        ARESETn = 0; CS = 1; OE = 1; arhns = 1; awhns = 1; whns = 1;
        addr = 16'h1234; wdata = 32'h5555_AAAA; cmd_ready = 1;
        step();
        step();
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (outst !== 4'd0) begin n_fail++; $display("FAIL reset_outst: got %0d expected 0", outst); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_err); end
        n_checks++; if ({cmd_we, cmd_addr, cmd_wdata} !== 49'd0) begin n_fail++; $display("FAIL reset_cmd: got %h expected 0", {cmd_we, cmd_addr, cmd_wdata}); end
        ARESETn = 1; cmd_ready = 0;
        step();
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_read();
        CS = 1; OE = 1; cmd_ready = 0;
        arhns = 1; addr = 16'h0010;
        step();
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL read_latency1: got %b expected 0", cmd_valid); end
        step();
        n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid: got %b expected 1", cmd_valid); end
        n_checks++; if (cmd_we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %b expected 0", cmd_we); end
        n_checks++; if (cmd_addr !== 16'h0010) begin n_fail++; $display("FAIL read_addr: got %h expected 0010", cmd_addr); end
        n_checks++; if (cmd_wdata !== 32'h0) begin n_fail++; $display("FAIL read_wdata: got %h expected 0", cmd_wdata); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL read_count1: got %0d expected 1", count); end
        n_checks++; if (outst !== 4'd1) begin n_fail++; $display("FAIL read_outst1: got %0d expected 1", outst); end
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL read_count0: got %0d expected 0", count); end
        n_checks++; if (outst !== 4'd1) begin n_fail++; $display("FAIL read_outst_after_pop: got %0d expected 1", outst); end
        rdfin = 1;
        step();
        n_checks++; if (outst !== 4'd0) begin n_fail++; $display("FAIL read_outst0: got %0d expected 0", outst); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL read_ovf: got %b expected 0", ovf_err); end
    endtask

    task automatic test_write_split();
        cmd_ready = 0;
        awhns = 1; addr = 16'h0020;
        step();
        addr = 16'hFFFF;
        step();
        step();
        whns = 1; wdata = 32'hDEAD_BEEF;
        step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wr_count_pending: got %0d expected 0", count); end
        step();
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL wr_count: got %0d expected 1", count); end
        n_checks++; if (cmd_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b expected 1", cmd_we); end
        n_checks++; if (cmd_addr !== 16'h0020) begin n_fail++; $display("FAIL wr_addr: got %h expected 0020", cmd_addr); end
        n_checks++; if (cmd_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata: got %h expected deadbeef", cmd_wdata); end
        n_checks++; if (outst !== 4'd1) begin n_fail++; $display("FAIL wr_outst: got %0d expected 1", outst); end
        do_reset();
    endtask

    task automatic test_priority();
        cmd_ready = 0;
        arhns = 1; awhns = 1; whns = 1; addr = 16'h0040; wdata = 32'hA5A5_0001;
        step();
        step();
        n_checks++; if ({count, cmd_we, cmd_addr} !== {3'd1, 1'b0, 16'h0040}) begin n_fail++; $display("FAIL prio_first: got cnt=%0d we=%b a=%h expected cnt=1 we=0 a=0040", count, cmd_we, cmd_addr); end
        step();
        n_checks++; if ({count, cmd_we} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL prio_second: got cnt=%0d we=%b expected cnt=2 we=0", count, cmd_we); end
        cmd_ready = 1;
        step();
        n_checks++; if ({cmd_we, cmd_addr, cmd_wdata} !== {1'b1, 16'h0040, 32'hA5A5_0001}) begin n_fail++; $display("FAIL prio_order: got we=%b a=%h d=%h expected we=1 a=0040 d=a5a50001", cmd_we, cmd_addr, cmd_wdata); end
        step();
        cmd_ready = 0;
        n_checks++; if ({count, outst} !== {3'd0, 4'd2}) begin n_fail++; $display("FAIL prio_drain: got cnt=%0d outst=%0d expected cnt=0 outst=2", count, outst); end
        rdfin = 1; wrfin = 1;
        step();
        n_checks++; if ({outst, ovf_err} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL prio_fin: got outst=%0d ovf=%b expected 0 0", outst, ovf_err); end
    endtask

    task automatic test_full();
        cmd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            arhns = 1; addr = 16'h0100 + 16'(i);
            step();
        end
        step();
        n_checks++; if ({full, count} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL full_flag: got full=%b cnt=%0d expected 1 4", full, count); end
        n_checks++; if (cmd_addr !== 16'h0100) begin n_fail++; $display("FAIL full_head: got %h expected 0100", cmd_addr); end
        n_checks++; if ({outst, ovf_err} !== {4'd4, 1'b0}) begin n_fail++; $display("FAIL full_outst: got outst=%0d ovf=%b expected 4 0", outst, ovf_err); end
        cmd_ready = 1;
        step();
        n_checks++; if ({full, count, outst} !== {1'b1, 3'd4, 4'd5}) begin n_fail++; $display("FAIL full_pushpop: got full=%b cnt=%0d outst=%0d expected 1 4 5", full, count, outst); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cmd_addr !== 16'h0101 + 16'(i)) begin n_fail++; $display("FAIL full_drain%0d: got %h expected %h", i, cmd_addr, 16'h0101 + 16'(i)); end
            step();
        end
        cmd_ready = 0;
        n_checks++; if ({cmd_valid, count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL full_empty: got v=%b cnt=%0d expected 0 0", cmd_valid, count); end
        do_reset();
    endtask

    task automatic test_errors();
        cmd_ready = 0;
        awhns = 1; addr = 16'h0050;
        step();
        awhns = 1; addr = 16'h0060;
        step();
        n_checks++; if ({ovf_err, count} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL err_aw_twice: got ovf=%b cnt=%0d expected 1 0", ovf_err, count); end
        whns = 1; wdata = 32'h1234_5678;
        step();
        step();
        n_checks++; if ({cmd_we, cmd_addr, cmd_wdata} !== {1'b1, 16'h0060, 32'h1234_5678}) begin n_fail++; $display("FAIL err_kept_addr: got we=%b a=%h d=%h expected 1 0060 12345678", cmd_we, cmd_addr, cmd_wdata); end
        do_reset();
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", ovf_err); end
        wrfin = 1;
        step();
        n_checks++; if ({ovf_err, outst} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL err_underflow: got ovf=%b outst=%0d expected 1 0", ovf_err, outst); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        cmd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            arhns = 1; addr = 16'h0200 + 16'(i);
            step();
        end
        awhns = 1; addr = 16'h0070;
        step();
        awhns = 1; addr = 16'h0071;
        step();
        n_checks++; if ({count, outst, ovf_err} !== {3'd3, 4'd3, 1'b1}) begin n_fail++; $display("FAIL mid_pre: got cnt=%0d outst=%0d ovf=%b expected 3 3 1", count, outst, ovf_err); end
        ARESETn = 0;
        step();
        ARESETn = 1;
        n_checks++; if ({count, cmd_valid, outst, ovf_err, full} !== {3'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL mid_post: got cnt=%0d v=%b outst=%0d ovf=%b full=%b expected all 0", count, cmd_valid, outst, ovf_err, full); end
        whns = 1; wdata = 32'h0BAD_F00D;
        step();
        step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_pend_dropped: got cnt=%0d expected 0", count); end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ARESETn   = ($urandom_range(0, 99) != 0);
            CS        = ($urandom_range(0, 9) != 0);
            OE        = ($urandom_range(0, 5) != 0);
            arhns     = ($urandom_range(0, 3) == 0);
            awhns     = ($urandom_range(0, 3) == 0);
            whns      = ($urandom_range(0, 3) == 0);
            rdfin     = ($urandom_range(0, 6) == 0);
            wrfin     = ($urandom_range(0, 6) == 0);
            cmd_ready = ($urandom_range(0, 2) == 0);
            addr      = 16'($urandom);
            wdata     = $urandom;
            step();
            n_checks++; if (cmd_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, cmd_valid, mq.size() != 0); end
            n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", i, count, mq.size()); end
            n_checks++; if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full@%0d: got %b expected %b", i, full, mq.size() == DEPTH); end
            n_checks++; if (outst !== 4'(m_outst)) begin n_fail++; $display("FAIL rnd_outst@%0d: got %0d expected %0d", i, outst, m_outst); end
            n_checks++; if (ovf_err !== m_err) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b expected %b", i, ovf_err, m_err); end
            if (mq.size() != 0) begin
                n_checks++; if ({cmd_we, cmd_addr, cmd_wdata} !== {mq[0].we, mq[0].a, mq[0].d}) begin n_fail++; $display("FAIL rnd_head@%0d: got we=%b a=%h d=%h expected we=%b a=%h d=%h", i, cmd_we, cmd_addr, cmd_wdata, mq[0].we, mq[0].a, mq[0].d); end
            end else begin
                n_checks++; if ({cmd_we, cmd_addr, cmd_wdata} !== 49'd0) begin n_fail++; $display("FAIL rnd_empty_cmd@%0d: got %h expected 0", i, {cmd_we, cmd_addr, cmd_wdata}); end
            end
        end
    endtask

    initial begin
        ARESETn = 0; CS = 0; OE = 0; arhns = 0; awhns = 0; whns = 0;
        rdfin = 0; wrfin = 0; cmd_ready = 0; addr = '0; wdata = '0;
        test_reset();
        test_read();
        test_write_split();
        test_priority();
        test_full();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
